calc1_port_sched: RTL and testbench
===================================

Name: calc1_port_sched

Overview:
- Front-end scheduler that shares one add/sub/shift ALU between four calc1-style requester ports.
- Each port runs the two-cycle calc1 request protocol: cmd + operand1 in one cycle, operand2 in the next.
- Pending requests are round-robin arbitrated onto a single valid/ready ALU issue interface.
- ALU results are routed back to the originating port as one-cycle resp/data pulses.

Parameters:
- DATA_W, 32, operand/result width.
- TAG_W, 2, ALU tag width; the tag carries the port index 0..3.

Ports:
- c_clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- reqN_cmd_in  in  4  per-port command, N=1..4 (0 none, 1 add, 2 sub, 5 shl, 6 shr)
- reqN_data_in  in  DATA_W  per-port operand bus, N=1..4
- out_respN  out  2  per-port response, N=1..4 (0 none, 1 success, 2 overflow/underflow/invalid)
- out_dataN  out  DATA_W  per-port result, N=1..4
- alu_valid  out  1  issue valid
- alu_ready  in  1  ALU accepts issue
- alu_cmd  out  4  issued command
- alu_op1, alu_op2  out  DATA_W  issued operands
- alu_tag  out  TAG_W  issuing port index
- alu_res_valid  in  1  result valid, one cycle per result
- alu_res_tag  in  TAG_W  tag of returning result
- alu_res_data  in  DATA_W  result value
- alu_res_err  in  1  overflow/underflow flag

Behaviour:
- Reset (asynchronous) clears all of the following:
  - all out_respN and out_dataN to 0;
  - alu_valid, alu_cmd, alu_op1, alu_op2 and alu_tag to 0;
  - all port FSMs to IDLE;
  - the round-robin pointer to port 1.
- Per-port FSM: IDLE -> OP2 -> PEND -> WAIT -> IDLE.
  - IDLE: a nonzero cmd at edge T latches cmd and op1; go to OP2. A cmd of 0 is ignored.
  - OP2: data at edge T+1 latches op2.
    - Valid cmd (1, 2, 5, 6): go to PEND.
    - Invalid cmd: go to IDLE; the response is resp=2, data=0, visible in the cycle after edge T+1. The ALU is never used.
  - PEND: eligible for arbitration starting the cycle after edge T+1.
  - WAIT: issued; waiting for a result whose tag equals this port.
- Commands presented while a port is not IDLE are ignored. Requesters must wait for a response before issuing again.
- Issue handshake:
  - Once asserted, alu_valid and its payload stay stable until alu_ready is sampled high.
  - Issue completes on the edge where alu_valid && alu_ready; the granted port moves PEND -> WAIT.
  - At most one issue per cycle. A new grant is driven in the cycle after acceptance, giving throughput of one issue per 2 cycles.
- Arbitration:
  - Round-robin over ports in PEND, searching from the pointer.
  - The pointer moves to (granted + 1) mod 4 only on accepted issue.
- Result routing:
  - On alu_res_valid, the port matching alu_res_tag, if in WAIT, registers its response and returns to IDLE.
  - Response values: resp=1 with data=alu_res_data; or resp=2 with data=0 when alu_res_err is high.
  - The response is visible for exactly one cycle, then resp and data return to 0.
  - A result whose tag names a port not in WAIT is discarded silently.
- Turnaround: a port may capture a new cmd in the same cycle its response is visible, because it is already IDLE.
- Simultaneous events: an issue accept and a result return in the same cycle are handled independently. A port may go PEND->WAIT and another WAIT->IDLE on the same edge.
- Reset mid-operation: all in-flight requests are dropped with no response. Results arriving after reset deassertion are discarded, since no port is in WAIT.
- Operands pass through unmodified; width and shift-amount checks belong to the ALU.

Optional Feature:
- Macro: CALC1_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority port1 > port2 > port3 > port4; the round-robin pointer is not implemented.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package calc1_pkg holds:
  - command constants CMD_NONE=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6;
  - response constants RESP_NONE=0, RESP_OK=1, RESP_ERR=2;
  - a port-state enum (IDLE, OP2, PEND, WAIT);
  - an is_valid_cmd function.
- One sub-module, calc1_sched_port: the per-port capture FSM and response register, instantiated 4 times.
- The arbiter and issue register stay in the top level.

Test Plan:
- Port1 cmd 1, op1=0x1, op2=0x01FF_FFFF; ALU model with 1-cycle ready and 2-cycle result -> alu_tag=0, out_resp1=1, out_data1=0x0200_0000 for exactly one cycle; other ports stay 0.
- All four ports issue cmd 1 on the same edge; ALU always ready -> grant order tags 0,1,2,3. A second identical round after pointer reset by traffic from port 3 only gives grant order 3, then ports 0,1,2 at their next requests.
- Port2 cmd 3 with op1=1 -> out_resp2=2, out_data2=0 one cycle after op2; alu_valid never asserts.
- Port1 issues while alu_ready is held low for 5 cycles -> alu_valid high and alu_cmd/op1/op2/tag stable all 5 cycles; accept occurs on the first ready edge.
- ALU returns alu_res_err=1 for port4 cmd 2, op1=1, op2=0xF -> out_resp4=2, out_data4=0.
- Assert reset while port3 is in WAIT, then return its result tag 2 after release -> all outputs 0, no response on port3, and port3 accepts a new command.

Source files
------------

// File: rtl/calc1_pkg.sv
// Shared definitions for the calc1 port scheduler: command/response codes,
// the per-port state encoding and the command legality check.
package calc1_pkg;

  localparam int NUM_PORTS = 4;

  localparam logic [3:0] CMD_NONE = 4'd0;
  localparam logic [3:0] CMD_ADD  = 4'd1;
  localparam logic [3:0] CMD_SUB  = 4'd2;
  localparam logic [3:0] CMD_SHL  = 4'd5;
  localparam logic [3:0] CMD_SHR  = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    OP2,
    PEND,
    WAIT
  } port_state_e;

  function automatic logic is_valid_cmd(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
           (cmd == CMD_SHL) || (cmd == CMD_SHR);
  endfunction

endpackage

// File: rtl/calc1_sched_port.sv
// One requester port: captures the two-cycle cmd/op1, op2 request, holds it
// until the shared ALU accepts it, and emits a one-cycle response pulse.
module calc1_sched_port
  import calc1_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [3:0]        i_cmd,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_grant,
  input  logic              i_res_valid,
  input  logic [DATA_W-1:0] i_res_data,
  input  logic              i_res_err,
  output logic              o_pend,
  output logic [3:0]        o_cmd,
  output logic [DATA_W-1:0] o_op1,
  output logic [DATA_W-1:0] o_op2,
  output logic [1:0]        o_resp,
  output logic [DATA_W-1:0] o_data
);

  port_state_e       r_state;
  port_state_e       w_state_nxt;
  logic [3:0]        r_cmd;
  logic [DATA_W-1:0] r_op1;
  logic [DATA_W-1:0] r_op2;
  logic [1:0]        r_resp;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: next state defaults to the current state first, so no branch can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (i_cmd != CMD_NONE) w_state_nxt = OP2;
      OP2:  w_state_nxt = is_valid_cmd(r_cmd) ? PEND : IDLE;
      PEND: if (i_grant) w_state_nxt = WAIT;
      WAIT: if (i_res_valid) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Response fields fall back to zero every cycle, so any response is a single-cycle pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cmd  <= CMD_NONE;
      r_op1  <= '0;
      r_op2  <= '0;
      r_resp <= RESP_NONE;
      r_data <= '0;
    end else begin
      r_resp <= RESP_NONE;
      r_data <= '0;
      case (r_state)
        IDLE: begin
          if (i_cmd != CMD_NONE) begin
            r_cmd <= i_cmd;
            r_op1 <= i_data;
          end
        end
        OP2: begin
          r_op2 <= i_data;
          if (!is_valid_cmd(r_cmd)) r_resp <= RESP_ERR;
        end
        WAIT: begin
          if (i_res_valid) begin
            if (i_res_err) begin
              r_resp <= RESP_ERR;
            end else begin
              r_resp <= RESP_OK;
              r_data <= i_res_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_pend = (r_state == PEND);
  assign o_cmd  = r_cmd;
  assign o_op1  = r_op1;
  assign o_op2  = r_op2;
  assign o_resp = r_resp;
  assign o_data = r_data;

endmodule

// File: rtl/calc1_port_sched.sv
// Shares one add/sub/shift ALU between four calc1 requester ports.
// Define CALC1_SCHED_FIXED_PRIO_EN for fixed port1>port2>port3>port4 priority instead of round-robin.
module calc1_port_sched
  import calc1_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 2
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req1_cmd_in,
  input  logic [3:0]        req2_cmd_in,
  input  logic [3:0]        req3_cmd_in,
  input  logic [3:0]        req4_cmd_in,
  input  logic [DATA_W-1:0] req1_data_in,
  input  logic [DATA_W-1:0] req2_data_in,
  input  logic [DATA_W-1:0] req3_data_in,
  input  logic [DATA_W-1:0] req4_data_in,
  output logic [1:0]        out_resp1,
  output logic [1:0]        out_resp2,
  output logic [1:0]        out_resp3,
  output logic [1:0]        out_resp4,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  output logic [DATA_W-1:0] out_data4,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [3:0]        alu_cmd,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [TAG_W-1:0]  alu_tag,
  input  logic              alu_res_valid,
  input  logic [TAG_W-1:0]  alu_res_tag,
  input  logic [DATA_W-1:0] alu_res_data,
  input  logic              alu_res_err
);

  logic [3:0]           w_cmd_in   [NUM_PORTS];
  logic [DATA_W-1:0]    w_data_in  [NUM_PORTS];
  logic [3:0]           w_port_cmd [NUM_PORTS];
  logic [DATA_W-1:0]    w_port_op1 [NUM_PORTS];
  logic [DATA_W-1:0]    w_port_op2 [NUM_PORTS];
  logic [1:0]           w_resp     [NUM_PORTS];
  logic [DATA_W-1:0]    w_data     [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_pend;

  logic                 r_alu_valid;
  logic [3:0]           r_alu_cmd;
  logic [DATA_W-1:0]    r_alu_op1;
  logic [DATA_W-1:0]    r_alu_op2;
  logic [1:0]           r_grant_idx;
  logic                 w_accept;
  logic                 w_sel_found;
  logic [1:0]           w_sel_idx;

  assign w_cmd_in[0]  = req1_cmd_in;
  assign w_cmd_in[1]  = req2_cmd_in;
  assign w_cmd_in[2]  = req3_cmd_in;
  assign w_cmd_in[3]  = req4_cmd_in;
  assign w_data_in[0] = req1_data_in;
  assign w_data_in[1] = req2_data_in;
  assign w_data_in[2] = req3_data_in;
  assign w_data_in[3] = req4_data_in;

  assign w_accept = r_alu_valid && alu_ready;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    calc1_sched_port #(
      .DATA_W (DATA_W)
    ) u_port (
      .i_clk       (c_clk),
      .i_rst       (reset),
      .i_cmd       (w_cmd_in[g]),
      .i_data      (w_data_in[g]),
      .i_grant     (w_accept && (r_grant_idx == 2'(g))),
      .i_res_valid (alu_res_valid && (alu_res_tag == TAG_W'(g))),
      .i_res_data  (alu_res_data),
      .i_res_err   (alu_res_err),
      .o_pend      (w_pend[g]),
      .o_cmd       (w_port_cmd[g]),
      .o_op1       (w_port_op1[g]),
      .o_op2       (w_port_op2[g]),
      .o_resp      (w_resp[g]),
      .o_data      (w_data[g])
    );
  end

`ifdef CALC1_SCHED_FIXED_PRIO_EN
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = 2'd0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (w_pend[i]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = 2'(i);
      end
    end
  end
`else
  logic [1:0] r_rr_ptr;

  // Search starts at the pointer and wraps; the 2-bit sum wraps modulo 4 by itself.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = r_rr_ptr;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_sel_found && w_pend[r_rr_ptr + 2'(i)]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = r_rr_ptr + 2'(i);
      end
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset)         r_rr_ptr <= 2'd0;
    else if (w_accept) r_rr_ptr <= r_grant_idx + 2'd1;
  end
`endif

  // A held request blocks new grants, so the payload stays frozen until accepted
  // and the next grant is loaded one cycle after the accept.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      r_alu_valid <= 1'b0;
      r_alu_cmd   <= CMD_NONE;
      r_alu_op1   <= '0;
      r_alu_op2   <= '0;
      r_grant_idx <= 2'd0;
    end else if (r_alu_valid) begin
      if (alu_ready) r_alu_valid <= 1'b0;
    end else if (w_sel_found) begin
      r_alu_valid <= 1'b1;
      r_alu_cmd   <= w_port_cmd[w_sel_idx];
      r_alu_op1   <= w_port_op1[w_sel_idx];
      r_alu_op2   <= w_port_op2[w_sel_idx];
      r_grant_idx <= w_sel_idx;
    end
  end

  assign alu_valid = r_alu_valid;
  assign alu_cmd   = r_alu_cmd;
  assign alu_op1   = r_alu_op1;
  assign alu_op2   = r_alu_op2;
  assign alu_tag   = TAG_W'(r_grant_idx);

  assign out_resp1 = w_resp[0];
  assign out_resp2 = w_resp[1];
  assign out_resp3 = w_resp[2];
  assign out_resp4 = w_resp[3];
  assign out_data1 = w_data[0];
  assign out_data2 = w_data[1];
  assign out_data3 = w_data[2];
  assign out_data4 = w_data[3];

endmodule

// File: tb/tb_calc1_port_sched.sv
// Directed self-checking bench for calc1_port_sched with a small ALU responder
// (ready under bench control, result two cycles after accept).
module tb_calc1_port_sched;
  import calc1_pkg::*;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 2;

  logic              c_clk = 1'b0;
  logic              reset;
  logic [3:0]        cmd_in  [4];
  logic [DATA_W-1:0] data_in [4];
  logic [1:0]        out_resp1, out_resp2, out_resp3, out_resp4;
  logic [DATA_W-1:0] out_data1, out_data2, out_data3, out_data4;
  logic              alu_valid, alu_ready;
  logic [3:0]        alu_cmd;
  logic [DATA_W-1:0] alu_op1, alu_op2;
  logic [TAG_W-1:0]  alu_tag;
  logic              alu_res_valid;
  logic [TAG_W-1:0]  alu_res_tag;
  logic [DATA_W-1:0] alu_res_data;
  logic              alu_res_err;

  logic [1:0]        resp_w [4];
  logic [DATA_W-1:0] data_w [4];

  always #5 c_clk = ~c_clk;

  calc1_port_sched #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .c_clk(c_clk), .reset(reset),
    .req1_cmd_in(cmd_in[0]), .req2_cmd_in(cmd_in[1]),
    .req3_cmd_in(cmd_in[2]), .req4_cmd_in(cmd_in[3]),
    .req1_data_in(data_in[0]), .req2_data_in(data_in[1]),
    .req3_data_in(data_in[2]), .req4_data_in(data_in[3]),
    .out_resp1(out_resp1), .out_resp2(out_resp2),
    .out_resp3(out_resp3), .out_resp4(out_resp4),
    .out_data1(out_data1), .out_data2(out_data2),
    .out_data3(out_data3), .out_data4(out_data4),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_cmd(alu_cmd),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_tag(alu_tag),
    .alu_res_valid(alu_res_valid), .alu_res_tag(alu_res_tag),
    .alu_res_data(alu_res_data), .alu_res_err(alu_res_err)
  );

  assign resp_w[0] = out_resp1;
  assign resp_w[1] = out_resp2;
  assign resp_w[2] = out_resp3;
  assign resp_w[3] = out_resp4;
  assign data_w[0] = out_data1;
  assign data_w[1] = out_data2;
  assign data_w[2] = out_data3;
  assign data_w[3] = out_data4;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ALU responder model
  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              err;
    int                due;
  } res_t;

  res_t res_q[$];
  int   grant_q[$];
  int   cyc = 0;
  bit   res_auto;

  function automatic res_t alu_model(input logic [3:0] cmd, input logic [31:0] a,
                                     input logic [31:0] b, input logic [1:0] tag, input int due);
    res_t r;
    logic [32:0] s;
    r.tag = tag; r.due = due; r.err = 1'b0; r.data = '0;
    case (cmd)
      CMD_ADD: begin s = {1'b0, a} + {1'b0, b}; r.data = s[31:0]; r.err = s[32]; end
      CMD_SUB: begin r.data = a - b; r.err = (b > a); end
      CMD_SHL: r.data = a << b[4:0];
      CMD_SHR: r.data = a >> b[4:0];
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  always @(posedge c_clk) begin
    cyc++;
    if (alu_valid && alu_ready) begin
      grant_q.push_back(int'(alu_tag));
      if (res_auto) res_q.push_back(alu_model(alu_cmd, alu_op1, alu_op2, alu_tag, cyc + 1));
    end
    if (res_auto) begin
      #1;
      if (res_q.size() > 0 && res_q[0].due == cyc) begin
        alu_res_valid = 1'b1;
        alu_res_tag   = res_q[0].tag;
        alu_res_data  = res_q[0].data;
        alu_res_err   = res_q[0].err;
        res_q.delete(0);
      end else begin
        alu_res_valid = 1'b0;
      end
    end
  end

  // Response monitor
  int                rsp_cnt  [4];
  logic [1:0]        rsp_seen [4];
  logic [DATA_W-1:0] dat_seen [4];
  int                valid_cnt;

  always @(negedge c_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (resp_w[i] != RESP_NONE) begin
        rsp_cnt[i]++;
        rsp_seen[i] = resp_w[i];
        dat_seen[i] = data_w[i];
      end
    end
    if (alu_valid) valid_cnt++;
  end

  logic [DATA_W-1:0] t_op1 [4];
  logic [DATA_W-1:0] t_op2 [4];

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge c_clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 4; i++) begin
      rsp_cnt[i] = 0; rsp_seen[i] = '0; dat_seen[i] = '0;
    end
    valid_cnt = 0;
    grant_q.delete();
  endtask

  task automatic send_mask(input logic [3:0] mask, input logic [3:0] cmd);
    for (int i = 0; i < 4; i++) if (mask[i]) begin cmd_in[i] = cmd; data_in[i] = t_op1[i]; end
    step();
    for (int i = 0; i < 4; i++) if (mask[i]) begin cmd_in[i] = CMD_NONE; data_in[i] = t_op2[i]; end
    step();
    for (int i = 0; i < 4; i++) if (mask[i]) data_in[i] = '0;
  endtask

  task automatic send(input int port, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    t_op1[port] = a;
    t_op2[port] = b;
    send_mask(4'b0001 << port, cmd);
  endtask

  task automatic load_table();
    for (int i = 0; i < 4; i++) begin
      t_op1[i] = 32'h100 * i + 32'h5;
      t_op2[i] = 32'h20 + i;
    end
  endtask

  task automatic wait_resp(input int port, input int bound);
    int k = 0;
    while (rsp_cnt[port] == 0 && k < bound) begin step(); k++; end
    check($sformatf("resp_seen_p%0d", port + 1), 64'(rsp_cnt[port] != 0), 64'd1);
  endtask

  task automatic wait_all(input int bound);
    int k = 0;
    while ((rsp_cnt[0] == 0 || rsp_cnt[1] == 0 || rsp_cnt[2] == 0 || rsp_cnt[3] == 0) && k < bound) begin
      step(); k++;
    end
    check("all_resp_seen", 64'(k < bound), 64'd1);
  endtask

  task automatic check_round(input string name, input int first);
    logic [DATA_W-1:0] exp_sum [4];
    exp_sum[0] = 32'h25; exp_sum[1] = 32'h126; exp_sum[2] = 32'h227; exp_sum[3] = 32'h328;
    check({name, "_grants"}, 64'(grant_q.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s_grant%0d", name, k),
            (k < grant_q.size()) ? 64'(grant_q[k]) : 64'hFFFF, 64'((first + k) % 4));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_cnt_p%0d", name, i + 1), 64'(rsp_cnt[i]), 64'd1);
      check($sformatf("%s_resp_p%0d", name, i + 1), 64'(rsp_seen[i]), 64'(RESP_OK));
      check($sformatf("%s_data_p%0d", name, i + 1), 64'(dat_seen[i]), 64'(exp_sum[i]));
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, 64'(alu_valid), 64'd0);
    check({name, "_cmd"},   64'(alu_cmd),   64'd0);
    check({name, "_op1"},   64'(alu_op1),   64'd0);
    check({name, "_op2"},   64'(alu_op2),   64'd0);
    check({name, "_tag"},   64'(alu_tag),   64'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_resp%0d", name, i + 1), 64'(resp_w[i]), 64'd0);
      check($sformatf("%s_data%0d", name, i + 1), 64'(data_w[i]), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    alu_ready = 1'b0;
    res_auto = 1'b1;
    alu_res_valid = 1'b0; alu_res_tag = '0; alu_res_data = '0; alu_res_err = 1'b0;
    for (int i = 0; i < 4; i++) begin cmd_in[i] = CMD_NONE; data_in[i] = '0; end
    clear_mon();
    step(2);
    check_all_zero("reset");
    reset = 1'b0;
    step();

    // Four simultaneous adds from pointer at port 1: tags 0,1,2,3
    alu_ready = 1'b1;
    clear_mon();
    load_table();
    send_mask(4'hF, CMD_ADD);
    wait_all(40);
    step(3);
    check_round("rr1", 0);

    // Single port-1 add with exact timing
    clear_mon();
    send(0, CMD_ADD, 32'h1, 32'h01FF_FFFF);
    step();
    check("p1_issue_valid", 64'(alu_valid), 64'd1);
    check("p1_issue_tag",   64'(alu_tag),   64'd0);
    check("p1_issue_cmd",   64'(alu_cmd),   64'(CMD_ADD));
    check("p1_issue_op1",   64'(alu_op1),   64'h1);
    check("p1_issue_op2",   64'(alu_op2),   64'h01FF_FFFF);
    step();
    check("p1_accepted", 64'(alu_valid), 64'd0);
    step();
    check("p1_resp_early", 64'(out_resp1), 64'd0);
    step();
    check("p1_resp", 64'(out_resp1), 64'(RESP_OK));
    check("p1_data", 64'(out_data1), 64'h0200_0000);
    step();
    check("p1_resp_drop", 64'(out_resp1), 64'd0);
    check("p1_data_drop", 64'(out_data1), 64'd0);
    check("p1_others", 64'(rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3]), 64'd0);

    // Port 3 alone moves the pointer to port 4
    clear_mon();
    send(2, CMD_ADD, 32'h100, 32'h11);
    wait_resp(2, 20);
    check("p3_data", 64'(dat_seen[2]), 64'h111);
    step(2);
    clear_mon();
    load_table();
    send_mask(4'hF, CMD_ADD);
    wait_all(40);
    step(3);
    check_round("rr2", 3);

    // Invalid command, then back-to-back turnaround in the response cycle
    clear_mon();
    send(1, 4'd3, 32'h1, 32'h55);
    check("inv_resp", 64'(out_resp2), 64'(RESP_ERR));
    check("inv_data", 64'(out_data2), 64'd0);
    send(1, 4'd7, 32'h2, 32'h3);
    check("inv2_resp", 64'(out_resp2), 64'(RESP_ERR));
    check("inv2_data", 64'(out_data2), 64'd0);
    step();
    check("inv_resp_drop", 64'(out_resp2), 64'd0);
    check("inv_cnt", 64'(rsp_cnt[1]), 64'd2);
    check("inv_no_issue", 64'(valid_cnt), 64'd0);

    // Backpressure: ready low for 5 cycles, payload must hold
    alu_ready = 1'b0;
    clear_mon();
    send(0, CMD_SHL, 32'h3, 32'h4);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("bp_valid%0d", k), 64'(alu_valid), 64'd1);
      check($sformatf("bp_cmd%0d", k),   64'(alu_cmd),   64'(CMD_SHL));
      check($sformatf("bp_op1%0d", k),   64'(alu_op1),   64'h3);
      check($sformatf("bp_op2%0d", k),   64'(alu_op2),   64'h4);
      check($sformatf("bp_tag%0d", k),   64'(alu_tag),   64'd0);
    end
    alu_ready = 1'b1;
    step();
    check("bp_accepted", 64'(alu_valid), 64'd0);
    check("bp_grants", 64'(grant_q.size()), 64'd1);
    wait_resp(0, 10);
    check("bp_resp", 64'(rsp_seen[0]), 64'(RESP_OK));
    check("bp_data", 64'(dat_seen[0]), 64'h30);

    // ALU error on port 4 subtract underflow
    clear_mon();
    send(3, CMD_SUB, 32'h1, 32'hF);
    wait_resp(3, 20);
    check("err_resp", 64'(rsp_seen[3]), 64'(RESP_ERR));
    check("err_data", 64'(dat_seen[3]), 64'd0);
    step(2);
    check("err_cnt", 64'(rsp_cnt[3]), 64'd1);

    // Reset while port 3 waits; a late result must be dropped
    res_auto = 1'b0;
    step();
    clear_mon();
    send(2, CMD_ADD, 32'h7, 32'h8);
    step();
    check("rst_issue_tag", 64'(alu_tag), 64'd2);
    step();
    check("rst_accepted", 64'(alu_valid), 64'd0);
    reset = 1'b1;
    step();
    check_all_zero("midrst");
    reset = 1'b0;
    step();
    alu_res_valid = 1'b1; alu_res_tag = 2'd2; alu_res_data = 32'hABCD; alu_res_err = 1'b0;
    step();
    alu_res_valid = 1'b0;
    step(3);
    check("late_res_dropped", 64'(rsp_cnt[2]), 64'd0);
    res_auto = 1'b1;
    clear_mon();
    send(2, CMD_SHR, 32'h80, 32'h3);
    wait_resp(2, 20);
    check("post_rst_resp", 64'(rsp_seen[2]), 64'(RESP_OK));
    check("post_rst_data", 64'(dat_seen[2]), 64'h10);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
